// File: rtl/fp_cvt_sequencer.sv
// Issue controller for the shared int->fp converter: accepts one FCVT.S.W/WU at a time,
// holds it on the converter for CVT_LAT cycles, then returns the captured result with its tag.
module fp_cvt_sequencer #(
  parameter int XLEN    = 32,
  parameter int RD_W    = 5,
  parameter int CVT_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_operand,
  input  logic            req_unsigned,
  input  logic [RD_W-1:0] req_rd,
  input  logic            flush,
  output logic [XLEN-1:0] cvt_operand,
  output logic            cvt_op,
  input  logic [XLEN-1:0] cvt_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic [RD_W-1:0] rsp_rd,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(CVT_LAT - 1);

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic [RD_W-1:0] tag;
  logic            accept;
  logic            capture;

  always_comb begin
    req_ready = 1'b0;
    case (state)
      IDLE:    req_ready = ~flush;
      DONE:    req_ready = rsp_ready & ~flush;
      default: req_ready = 1'b0;
    endcase
    if (rst) req_ready = 1'b0;
  end

  assign accept  = req_valid & req_ready;
  assign capture = (state == EXEC) && (cnt == 4'd0) && !flush;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: if (cnt == 4'd0) state_nxt = DONE;
      DONE: if (rsp_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      tag         <= '0;
      cvt_operand <= '0;
      cvt_op      <= 1'b0;
      rsp_result  <= '0;
      rsp_rd      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cvt_operand <= req_operand;
        cvt_op      <= req_unsigned;
        tag         <= req_rd;
        cnt         <= CNT_INIT;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_result <= cvt_result;
        rsp_rd     <= tag;
      end
    end
  end

  // A flushed DONE result must not look like a completed handshake to writeback.
  assign rsp_valid = (state == DONE) && !flush;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp_cvt_sequencer.sv
// Scoreboard bench for fp_cvt_sequencer: two instances (CVT_LAT=1 and 3) with a behavioural
// int->fp converter; stimulus pushes hand-computed results, a negedge monitor pops and compares.
module tb_fp_cvt_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic [31:0] req_operand  [2];
  logic        req_unsigned [2];
  logic [4:0]  req_rd       [2];
  logic        flush        [2];
  logic [31:0] cvt_operand  [2];
  logic        cvt_op       [2];
  logic [31:0] cvt_result   [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_result   [2];
  logic [4:0]  rsp_rd       [2];
  logic        busy         [2];

  typedef struct {
    logic [31:0] opnd;
    logic        op;
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  bit   head_seen;
  int   sel;
  int   cyc;
  int   checks;
  int   errors;

  // Round-to-nearest-even int32/uint32 -> binary32, standing in for the external converter.
  function automatic logic [31:0] i2f(input logic [31:0] v, input logic u);
    logic        s;
    logic [31:0] m, mant, rem, half;
    int          p, sh;
    s = !u && v[31];
    m = s ? (~v + 32'd1) : v;
    if (m == 32'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    if (p <= 23) mant = m << (23 - p);
    else begin
      sh   = p - 23;
      mant = m >> sh;
      rem  = m & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 32'd1;
      if (mant[24]) begin
        mant = mant >> 1;
        p    = p + 1;
      end
    end
    return {s, 8'(p + 127), mant[22:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fp_cvt_sequencer #(.XLEN(32), .RD_W(5), .CVT_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst(rst[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_operand(req_operand[g]),
      .req_unsigned(req_unsigned[g]), .req_rd(req_rd[g]), .flush(flush[g]),
      .cvt_operand(cvt_operand[g]), .cvt_op(cvt_op[g]), .cvt_result(cvt_result[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_result(rsp_result[g]),
      .rsp_rd(rsp_rd[g]), .busy(busy[g])
    );
    assign cvt_result[g] = i2f(cvt_operand[g], cvt_op[g]);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cyc %0d inst %0d)", name, act, exp, cyc, sel);
    end
  endtask

  // Monitor: result/tag/latency on every valid cycle, converter inputs held during EXEC.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rsp_valid[s]) begin
        if (s != sel || q.size() == 0) chk("unexpected_rsp_valid", 32'd1, 32'd0);
        else begin
          if (!head_seen) begin
            chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            head_seen = 1'b1;
          end
          chk("rsp_result", rsp_result[s], q[0].res);
          chk("rsp_rd", 32'(rsp_rd[s]), 32'(q[0].rd));
          if (rsp_ready[s]) begin
            void'(q.pop_front());
            head_seen = 1'b0;
          end
        end
      end else if (s == sel && busy[s] && q.size() > 0 && !flush[s] && !rst[s]) begin
        chk("cvt_operand_held", cvt_operand[s], q[0].opnd);
        chk("cvt_op_held", 32'(cvt_op[s]), 32'(q[0].op));
      end
    end
  end

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] opnd, input logic u, input logic [4:0] rd,
                       input logic [31:0] res, output int acc, output int waited);
    exp_t e;
    req_operand[sel]  = opnd;
    req_unsigned[sel] = u;
    req_rd[sel]       = rd;
    req_valid[sel]    = 1'b1;
    waited = 0;
    acc    = 0;
    @(negedge clk);
    while (!req_ready[sel] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready[sel]) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      acc    = cyc + 1;
      e.opnd = opnd; e.op = u; e.res = res; e.rd = rd; e.acc = acc; e.lat = lat_of(sel);
      q.push_back(e);
    end
    tick();
    req_valid[sel] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy[sel] || q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy[sel] || q.size() != 0) chk("idle_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic wait_rsp_valid();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[sel]) chk("rsp_valid_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_cvt_operand"}, cvt_operand[sel], 32'd0);
    chk({tagname, "_cvt_op"}, 32'(cvt_op[sel]), 32'd0);
    chk({tagname, "_rsp_result"}, rsp_result[sel], 32'd0);
    chk({tagname, "_rsp_rd"}, 32'(rsp_rd[sel]), 32'd0);
    chk({tagname, "_rsp_valid"}, 32'(rsp_valid[sel]), 32'd0);
    chk({tagname, "_busy"}, 32'(busy[sel]), 32'd0);
  endtask

  task automatic drop_pending();
    q.delete();
    head_seen = 1'b0;
  endtask

  initial begin
    int acc1, acc2, w;
    checks = 0; errors = 0; cyc = 0; sel = 0; head_seen = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; req_valid[s] = 1'b0; req_operand[s] = '0; req_unsigned[s] = 1'b0;
      req_rd[s] = '0; flush[s] = 1'b0; rsp_ready[s] = 1'b1;
    end
    tick(); tick();
    @(negedge clk);
    chk("req_ready_in_reset", 32'(req_ready[0]), 32'd0);
    chk_reset_outputs("reset");
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", 32'(req_ready[0]), 32'd1);
    tick();

    // CVT_LAT=1: signed/unsigned -1, extremes, zero; back-to-back throughput
    sel = 0;
    issue(32'hFFFF_FFFF, 1'b0, 5'd3, 32'hBF80_0000, acc1, w);
    wait_idle();
    issue(32'hFFFF_FFFF, 1'b1, 5'd4, 32'h4F80_0000, acc1, w);
    issue(32'h8000_0000, 1'b0, 5'd7, 32'hCF00_0000, acc2, w);
    chk("throughput_lat1", 32'(acc2 - acc1), 32'd2);
    issue(32'h8000_0000, 1'b1, 5'd8, 32'h4F00_0000, acc1, w);
    issue(32'h0000_0000, 1'b0, 5'd9, 32'h0000_0000, acc1, w);
    issue(32'h0000_0064, 1'b0, 5'd31, 32'h42C8_0000, acc1, w);
    wait_idle();

    // CVT_LAT=3
    sel = 1;
    issue(32'h0000_0007, 1'b0, 5'd2, 32'h40E0_0000, acc1, w);
    issue(32'hFFFF_FFFE, 1'b0, 5'd5, 32'hC000_0000, acc2, w);
    chk("throughput_lat3", 32'(acc2 - acc1), 32'd4);
    wait_idle();

    // Backpressure for 5 cycles, then both handshakes in one cycle
    rsp_ready[1] = 1'b0;
    issue(32'h0000_0001, 1'b0, 5'd6, 32'h3F80_0000, acc1, w);
    wait_rsp_valid();
    req_operand[1] = 32'h0000_000A; req_unsigned[1] = 1'b1; req_rd[1] = 5'd13; req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("req_ready_backpressure", 32'(req_ready[1]), 32'd0);
      tick();
    end
    rsp_ready[1] = 1'b1;
    issue(32'h0000_000A, 1'b1, 5'd13, 32'h4120_0000, acc1, w);
    chk("b2b_same_cycle", 32'(w), 32'd0);
    wait_idle();

    // Flush during EXEC with a concurrent request
    issue(32'h0000_0005, 1'b0, 5'd10, 32'h40A0_0000, acc1, w);
    tick();
    flush[1] = 1'b1; req_valid[1] = 1'b1; req_operand[1] = 32'h0000_0011;
    @(negedge clk);
    chk("flush_exec_req_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk);
    drop_pending();
    #1 flush[1] = 1'b0; req_valid[1] = 1'b0;
    @(negedge clk);
    chk("flush_exec_busy", 32'(busy[1]), 32'd0);
    chk("flush_exec_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    tick(); tick(); tick(); tick();

    // Flush during DONE while writeback is ready
    rsp_ready[1] = 1'b0;
    issue(32'h0000_0003, 1'b0, 5'd11, 32'h4040_0000, acc1, w);
    wait_rsp_valid();
    rsp_ready[1] = 1'b1; flush[1] = 1'b1; req_valid[1] = 1'b1;
    @(negedge clk);
    chk("flush_done_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("flush_done_req_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk);
    drop_pending();
    #1 flush[1] = 1'b0; req_valid[1] = 1'b0;
    @(negedge clk);
    chk("flush_done_busy", 32'(busy[1]), 32'd0);
    chk("flush_done_rsp_valid_next", 32'(rsp_valid[1]), 32'd0);
    tick(); tick();

    // Reset pulse mid-EXEC
    issue(32'h0000_0009, 1'b1, 5'd12, 32'h4110_0000, acc1, w);
    rst[1] = 1'b1; req_valid[1] = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready[1]), 32'd0);
    @(posedge clk);
    drop_pending();
    #1 rst[1] = 1'b0; req_valid[1] = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    chk("req_ready_after_rst", 32'(req_ready[1]), 32'd1);
    tick();
    issue(32'h0000_0064, 1'b1, 5'd1, 32'h42C8_0000, acc1, w);
    wait_idle();

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
